game_ctrl: RTL and testbench
============================

GAME_CTRL -- requirements
Module: game_ctrl

Interface
REQ-001 SHALL have parameter SCORE_DIV, default 6: i_ani_stb frames per score point.
REQ-002 SHALL have parameter START_SPEED, default 4'd2: scroll speed after each start.
REQ-003 SHALL have parameter MAX_SPEED, default 4'd9: speed saturation value.
REQ-004 SHALL have parameter HOLD_FRAMES, default 60: i_ani_stb frames in OVER before a restart is accepted.
REQ-005 SHALL have port i_clk  input  1  single base clock; all state updates occur on its rising edge.
REQ-006 SHALL have port i_rst  input  1  reset, synchronous, active-high.
REQ-007 SHALL have port i_ani_stb  input  1  one-clock frame strobe.
REQ-008 SHALL have port i_jump  input  1  jump button level, also used as the start/restart button.
REQ-009 SHALL have port i_collide  input  1  dino/obstacle overlap level from the pixel logic.
REQ-010 SHALL have port o_state  output  2  game state: IDLE=0, START=1, RUN=2, OVER=3.
REQ-011 SHALL have port o_animate  output  1  drives i_animate of dinosaur and obstacle blocks.
REQ-012 SHALL have port o_obj_rst  output  1  drives i_rst of dinosaur and obstacle blocks.
REQ-013 SHALL have port o_score  output  16  current score as 4 packed BCD digits.
REQ-014 SHALL have port o_hiscore  output  16  high score as 4 packed BCD digits.
REQ-015 SHALL have port o_speed  output  4  obstacle scroll speed in pixels/frame.
REQ-016 SHALL have port o_new_hi  output  1  high when the last game set a new high score.

Function
REQ-017 SHALL register jump_prev <= i_jump on every i_ani_stb in all states; start_req = i_ani_stb && i_jump && !jump_prev.
REQ-018 SHALL, in IDLE, hold o_animate=0 and go to START on start_req.
REQ-019 SHALL, in START (exactly one clock), set o_score=0, o_speed=START_SPEED, o_new_hi=0, and frame counter=0; next state is RUN.
REQ-020 SHALL drive o_obj_rst = i_rst OR (state==START), combinationally.
REQ-021 SHALL drive o_animate=1 only in RUN.
REQ-022 SHALL, in RUN on each i_ani_stb, increment the frame counter, wrapping at SCORE_DIV-1 to 0; the wrap cycle adds 1 to o_score with BCD carry.
REQ-023 SHALL saturate o_score at 16'h9999 with no wrap.
REQ-024 SHALL increment o_speed by 1 when the score increment produces low two digits 00 (every 100 points), saturating at MAX_SPEED.
REQ-025 SHALL, when i_collide=1 on any RUN clock, go to OVER on the next clock; collision has priority, so no score or speed update occurs that cycle.
REQ-026 SHALL, on OVER entry, load o_hiscore=o_score and set o_new_hi=1 when o_score > o_hiscore (packed-BCD compare equals numeric compare); otherwise both are unchanged.
REQ-027 SHALL, in OVER, hold o_animate=0 and freeze o_score and o_speed.
REQ-028 SHALL, in OVER, count i_ani_stb up to HOLD_FRAMES; start_req is ignored until the count reaches HOLD_FRAMES, and then goes to START.
REQ-029 SHALL clear the hold counter on OVER entry.
REQ-030 SHALL ignore i_collide in IDLE, START and OVER.
REQ-031 SHALL make a held i_jump never cause a restart; a release (seen at a strobe) then a press is required.

Reset
REQ-032 SHALL, while i_rst=1, set: state=IDLE, o_score=0, o_hiscore=0, o_speed=START_SPEED, o_new_hi=0, counters=0, jump_prev=0, o_animate=0, o_obj_rst=1.
REQ-033 SHALL, when i_rst is asserted in any state including mid-RUN, take priority over all other updates and drop the high score.

Verification
REQ-034 SHALL cover: reset, then i_jump high at strobe -> o_state START for 1 clk with o_obj_rst=1, then RUN with o_animate=1, o_speed=2.
REQ-035 SHALL cover: RUN for 600 strobes with SCORE_DIV=6 -> o_score=16'h0100 and o_speed=3; score 16'h0099 then 16'h0100 checks the BCD carry.
REQ-036 SHALL cover: o_score forced near 16'h9999, more strobes -> stays 16'h9999; speed stays at MAX_SPEED=9 after 8 increments.
REQ-037 SHALL cover: i_collide pulse coinciding with a score-wrap strobe at score 16'h0042 -> OVER, o_score=16'h0042, o_hiscore=16'h0042, o_new_hi=1.
REQ-038 SHALL cover: in OVER, press at strobe 10 -> no restart; i_jump held through strobe 60 -> no restart; release then press -> START; a second game ending at score 16'h0010 -> o_hiscore stays 16'h0042 and o_new_hi=0.
REQ-039 SHALL cover: i_rst mid-RUN -> next clock IDLE, o_score=0, o_hiscore=0, o_animate=0.

Source files
------------

// File: rtl/game_ctrl.sv
// Game sequencer: start/run/over state machine, BCD score, high score and scroll speed.
// Latency: state and counters update one clock after the qualifying strobe/input; o_obj_rst is combinational.
// Backpressure: none; inputs are sampled every clock and strobes are never stalled.
module game_ctrl #(
  parameter int         SCORE_DIV   = 6,
  parameter logic [3:0] START_SPEED = 4'd2,
  parameter logic [3:0] MAX_SPEED   = 4'd9,
  parameter int         HOLD_FRAMES = 60
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_ani_stb,
  input  logic        i_jump,
  input  logic        i_collide,
  output logic [1:0]  o_state,
  output logic        o_animate,
  output logic        o_obj_rst,
  output logic [15:0] o_score,
  output logic [15:0] o_hiscore,
  output logic [3:0]  o_speed,
  output logic        o_new_hi
);

  localparam int FW = $clog2(SCORE_DIV + 1);
  localparam int HW = $clog2(HOLD_FRAMES + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    RUN   = 2'd2,
    OVER  = 2'd3
  } state_t;

  state_t          state_q, state_d;
  logic [15:0]     score_q, hiscore_q;
  logic [3:0]      speed_q;
  logic            new_hi_q;
  logic [FW-1:0]   frame_cnt_q;
  logic [HW-1:0]   hold_cnt_q;
  logic            jump_prev_q;
  logic            start_req;
  logic            hold_done;
  logic [15:0]     score_inc;

  // Rising edge of the jump button as seen at frame strobes; a held button never retriggers.
  assign start_req = i_ani_stb && i_jump && !jump_prev_q;
  assign hold_done = (hold_cnt_q == HW'(HOLD_FRAMES));

  // Packed-BCD increment of the score, ripple carry from the low digit upward.
  always_comb begin
    logic carry;
    score_inc = score_q;
    carry     = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (carry) begin
        if (score_inc[i*4 +: 4] == 4'd9) begin
          score_inc[i*4 +: 4] = 4'd0;
        end else begin
          score_inc[i*4 +: 4] = score_inc[i*4 +: 4] + 4'd1;
          carry = 1'b0;
        end
      end
    end
  end

  // State register.
  always_ff @(posedge i_clk) begin
    if (i_rst) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic; collision only matters while running.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:  if (start_req) state_d = START;
      START: state_d = RUN;
      RUN:   if (i_collide) state_d = OVER;
      OVER:  if (start_req && hold_done) state_d = START;
      default: state_d = IDLE;
    endcase
  end

  // Score, speed, high score and frame/hold counters.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      score_q     <= 16'h0000;
      hiscore_q   <= 16'h0000;
      speed_q     <= START_SPEED;
      new_hi_q    <= 1'b0;
      frame_cnt_q <= '0;
      hold_cnt_q  <= '0;
      jump_prev_q <= 1'b0;
    end else begin
      if (i_ani_stb) jump_prev_q <= i_jump;
      unique case (state_q)
        START: begin
          score_q     <= 16'h0000;
          speed_q     <= START_SPEED;
          new_hi_q    <= 1'b0;
          frame_cnt_q <= '0;
        end
        RUN: begin
          if (i_collide) begin
            // Game ends: no score/speed update this cycle, capture the high score.
            hold_cnt_q <= '0;
            if (score_q > hiscore_q) begin
              hiscore_q <= score_q;
              new_hi_q  <= 1'b1;
            end
          end else if (i_ani_stb) begin
            if (frame_cnt_q == FW'(SCORE_DIV - 1)) begin
              frame_cnt_q <= '0;
              if (score_q != 16'h9999) begin
                score_q <= score_inc;
                if (score_inc[7:0] == 8'h00 && speed_q < MAX_SPEED)
                  speed_q <= speed_q + 4'd1;
              end
            end else begin
              frame_cnt_q <= frame_cnt_q + FW'(1);
            end
          end
        end
        OVER: begin
          if (i_ani_stb && !hold_done) hold_cnt_q <= hold_cnt_q + HW'(1);
        end
        default: ;
      endcase
    end
  end

  assign o_state   = state_q;
  assign o_animate = (state_q == RUN);
  assign o_obj_rst = i_rst || (state_q == START);
  assign o_score   = score_q;
  assign o_hiscore = hiscore_q;
  assign o_speed   = speed_q;
  assign o_new_hi  = new_hi_q;

endmodule

// File: tb/tb_game_ctrl.sv
// Directed bench for game_ctrl: one default instance plus a SCORE_DIV=1 instance for saturation.
// Inputs change 1 time unit after a rising edge; outputs are sampled at that same point.
// Every check is inline; a single summary line ends the run.
module tb_game_ctrl;

  logic        i_clk = 1'b0;
  logic        i_rst, i_ani_stb, i_jump, i_collide;
  logic [1:0]  o_state;
  logic        o_animate, o_obj_rst, o_new_hi;
  logic [15:0] o_score, o_hiscore;
  logic [3:0]  o_speed;

  logic        f_stb, f_jump, f_collide;
  logic [1:0]  f_state;
  logic        f_animate, f_obj_rst, f_new_hi;
  logic [15:0] f_score, f_hiscore;
  logic [3:0]  f_speed;

  int checks = 0;
  int failures = 0;

  always #5 i_clk = ~i_clk;

  game_ctrl dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_ani_stb(i_ani_stb), .i_jump(i_jump),
    .i_collide(i_collide), .o_state(o_state), .o_animate(o_animate),
    .o_obj_rst(o_obj_rst), .o_score(o_score), .o_hiscore(o_hiscore),
    .o_speed(o_speed), .o_new_hi(o_new_hi)
  );

  game_ctrl #(.SCORE_DIV(1), .HOLD_FRAMES(4)) dut_fast (
    .i_clk(i_clk), .i_rst(i_rst), .i_ani_stb(f_stb), .i_jump(f_jump),
    .i_collide(f_collide), .o_state(f_state), .o_animate(f_animate),
    .o_obj_rst(f_obj_rst), .o_score(f_score), .o_hiscore(f_hiscore),
    .o_speed(f_speed), .o_new_hi(f_new_hi)
  );

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  // One frame strobe with the given jump level and collide value.
  task automatic stb(input logic j, input logic c);
    i_jump = j; i_collide = c; i_ani_stb = 1'b1;
    tick();
    i_ani_stb = 1'b0; i_collide = 1'b0;
  endtask

  task automatic test_reset();
    i_rst = 1'b1; i_ani_stb = 1'b0; i_jump = 1'b0; i_collide = 1'b0;
    f_stb = 1'b0; f_jump = 1'b0; f_collide = 1'b0;
    tick(); tick();
    checks++; if (o_state !== 2'd0) begin failures++; $display("FAIL rst_state got=%0d exp=0", o_state); end
    checks++; if (o_score !== 16'h0) begin failures++; $display("FAIL rst_score got=%h exp=0000", o_score); end
    checks++; if (o_hiscore !== 16'h0) begin failures++; $display("FAIL rst_hiscore got=%h exp=0000", o_hiscore); end
    checks++; if (o_speed !== 4'd2) begin failures++; $display("FAIL rst_speed got=%0d exp=2", o_speed); end
    checks++; if (o_new_hi !== 1'b0 || o_animate !== 1'b0) begin failures++; $display("FAIL rst_flags new_hi=%b animate=%b exp=0,0", o_new_hi, o_animate); end
    checks++; if (o_obj_rst !== 1'b1) begin failures++; $display("FAIL rst_obj_rst got=%b exp=1", o_obj_rst); end
    i_rst = 1'b0;
    tick();
    checks++; if (o_obj_rst !== 1'b0) begin failures++; $display("FAIL idle_obj_rst got=%b exp=0", o_obj_rst); end
    // Collision is ignored while idle.
    stb(1'b0, 1'b1);
    checks++; if (o_state !== 2'd0) begin failures++; $display("FAIL idle_collide state got=%0d exp=0", o_state); end
  endtask

  task automatic test_start();
    stb(1'b1, 1'b0);
    checks++; if (o_state !== 2'd1 || o_obj_rst !== 1'b1) begin failures++; $display("FAIL start state=%0d obj_rst=%b exp=1,1", o_state, o_obj_rst); end
    checks++; if (o_animate !== 1'b0) begin failures++; $display("FAIL start_animate got=%b exp=0", o_animate); end
    tick();
    checks++; if (o_state !== 2'd2 || o_animate !== 1'b1) begin failures++; $display("FAIL run_entry state=%0d animate=%b exp=2,1", o_state, o_animate); end
    checks++; if (o_speed !== 4'd2 || o_score !== 16'h0 || o_obj_rst !== 1'b0) begin failures++; $display("FAIL run_entry speed=%0d score=%h obj_rst=%b exp=2,0000,0", o_speed, o_score, o_obj_rst); end
  endtask

  // 257 strobes: score 42, frame counter at 5, so the next strobe would wrap.
  task automatic test_collide_wrap();
    for (int i = 0; i < 257; i++) stb(1'b0, 1'b0);
    checks++; if (o_score !== 16'h0042) begin failures++; $display("FAIL pre_collide_score got=%h exp=0042", o_score); end
    stb(1'b0, 1'b1);
    checks++; if (o_state !== 2'd3 || o_animate !== 1'b0) begin failures++; $display("FAIL collide state=%0d animate=%b exp=3,0", o_state, o_animate); end
    checks++; if (o_score !== 16'h0042) begin failures++; $display("FAIL collide_score got=%h exp=0042", o_score); end
    checks++; if (o_hiscore !== 16'h0042 || o_new_hi !== 1'b1) begin failures++; $display("FAIL collide_hi hiscore=%h new_hi=%b exp=0042,1", o_hiscore, o_new_hi); end
  endtask

  task automatic test_over_hold();
    for (int i = 1; i <= 9; i++) stb(1'b0, (i == 3));
    stb(1'b1, 1'b0);
    checks++; if (o_state !== 2'd3) begin failures++; $display("FAIL early_press state=%0d exp=3", o_state); end
    for (int i = 11; i <= 60; i++) stb(1'b1, 1'b0);
    checks++; if (o_state !== 2'd3) begin failures++; $display("FAIL held_jump state=%0d exp=3", o_state); end
    checks++; if (o_score !== 16'h0042 || o_speed !== 4'd2) begin failures++; $display("FAIL over_frozen score=%h speed=%0d exp=0042,2", o_score, o_speed); end
    stb(1'b0, 1'b0);
    checks++; if (o_state !== 2'd3) begin failures++; $display("FAIL release state=%0d exp=3", o_state); end
    stb(1'b1, 1'b0);
    checks++; if (o_state !== 2'd1 || o_obj_rst !== 1'b1) begin failures++; $display("FAIL restart state=%0d obj_rst=%b exp=1,1", o_state, o_obj_rst); end
    tick();
    checks++; if (o_state !== 2'd2 || o_score !== 16'h0 || o_new_hi !== 1'b0) begin failures++; $display("FAIL game2_entry state=%0d score=%h new_hi=%b exp=2,0000,0", o_state, o_score, o_new_hi); end
    for (int i = 0; i < 60; i++) stb(1'b0, 1'b0);
    i_collide = 1'b1; tick(); i_collide = 1'b0;
    checks++; if (o_state !== 2'd3 || o_score !== 16'h0010) begin failures++; $display("FAIL game2_over state=%0d score=%h exp=3,0010", o_state, o_score); end
    checks++; if (o_hiscore !== 16'h0042 || o_new_hi !== 1'b0) begin failures++; $display("FAIL game2_hi hiscore=%h new_hi=%b exp=0042,0", o_hiscore, o_new_hi); end
  endtask

  task automatic test_score_carry();
    for (int i = 0; i < 60; i++) stb(1'b0, 1'b0);
    stb(1'b1, 1'b0);
    tick();
    checks++; if (o_state !== 2'd2) begin failures++; $display("FAIL game3_entry state=%0d exp=2", o_state); end
    for (int i = 0; i < 594; i++) stb(1'b0, 1'b0);
    checks++; if (o_score !== 16'h0099 || o_speed !== 4'd2) begin failures++; $display("FAIL score_99 score=%h speed=%0d exp=0099,2", o_score, o_speed); end
    for (int i = 0; i < 6; i++) stb(1'b0, 1'b0);
    checks++; if (o_score !== 16'h0100 || o_speed !== 4'd3) begin failures++; $display("FAIL score_100 score=%h speed=%0d exp=0100,3", o_score, o_speed); end
  endtask

  task automatic test_reset_mid_run();
    stb(1'b0, 1'b0);
    i_rst = 1'b1;
    tick();
    checks++; if (o_state !== 2'd0 || o_animate !== 1'b0) begin failures++; $display("FAIL midrst state=%0d animate=%b exp=0,0", o_state, o_animate); end
    checks++; if (o_score !== 16'h0 || o_hiscore !== 16'h0) begin failures++; $display("FAIL midrst score=%h hiscore=%h exp=0000,0000", o_score, o_hiscore); end
    i_rst = 1'b0;
    tick();
  endtask

  task automatic test_saturate();
    f_stb = 1'b1; f_jump = 1'b1;
    tick();
    checks++; if (f_state !== 2'd1 || f_obj_rst !== 1'b1) begin failures++; $display("FAIL fast_start state=%0d obj_rst=%b exp=1,1", f_state, f_obj_rst); end
    f_stb = 1'b0; f_jump = 1'b0;
    tick();
    f_stb = 1'b1;
    for (int i = 0; i < 9999; i++) tick();
    checks++; if (f_score !== 16'h9999 || f_speed !== 4'd9) begin failures++; $display("FAIL sat_reach score=%h speed=%0d exp=9999,9", f_score, f_speed); end
    for (int i = 0; i < 20; i++) tick();
    checks++; if (f_score !== 16'h9999 || f_speed !== 4'd9 || f_animate !== 1'b1) begin failures++; $display("FAIL sat_hold score=%h speed=%0d animate=%b exp=9999,9,1", f_score, f_speed, f_animate); end
    f_stb = 1'b0; f_collide = 1'b1;
    tick();
    f_collide = 1'b0;
    checks++; if (f_state !== 2'd3 || f_hiscore !== 16'h9999 || f_new_hi !== 1'b1) begin failures++; $display("FAIL sat_over state=%0d hiscore=%h new_hi=%b exp=3,9999,1", f_state, f_hiscore, f_new_hi); end
  endtask

  initial begin
    test_reset();
    test_start();
    test_collide_wrap();
    test_over_hold();
    test_score_carry();
    test_reset_mid_run();
    test_saturate();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
